// File: rtl/wb_bus_master_if.sv
// Wishbone master bridge for one pipeline memory port (IF or MEM), driving stall requests.
// Optional macro WB_TIMEOUT_EN adds a bus-cycle timeout that aborts the access and pulses bus_err_o.
module wb_bus_master_if #(
    parameter int STALL_BIT      = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_wb_addr;
    logic [31:0] r_wb_data;
    logic        r_wb_we;
    logic [3:0]  r_wb_sel;
    logic        r_wb_stb;
    logic        r_wb_cyc;
    logic [31:0] r_rd_buf;
    logic        w_own_stall;
    logic        w_start;
    logic        w_done;
    logic        w_drop;
    logic        w_tmo;
    logic        w_unused;

    assign w_own_stall = stall_i[STALL_BIT];
    assign w_start     = (r_state == S_IDLE) && cpu_ce_i && !flush_i;
    assign w_done      = (r_state == S_BUSY) && wb_ack_i && !flush_i;
    assign w_drop      = (r_state == S_BUSY) && flush_i;
    assign w_unused    = ^{stall_i, 8'(TIMEOUT_CYCLES)};

`ifdef WB_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_bus_err;

    assign w_tmo = (r_state == S_BUSY) && !wb_ack_i && !flush_i &&
                   (r_tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Timeout counter counts unacknowledged BUSY cycles; abort raises a one-cycle error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= 8'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_tmo;
            if (w_start) begin
                r_tmo_cnt <= 8'd0;
            end else if ((r_state == S_BUSY) && !wb_ack_i && !flush_i) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
        end
    end

    assign bus_err_o = r_bus_err;
`else
    assign w_tmo     = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush outranks ack, and WAIT never launches a new access
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = S_BUSY;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    w_next = S_IDLE;
                end else if (wb_ack_i) begin
                    w_next = w_own_stall ? S_WAIT : S_IDLE;
                end else if (w_tmo) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_BUSY;
                end
            end
            S_WAIT: begin
                if (flush_i || !w_own_stall) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Registered Wishbone request and held read result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_addr <= 32'd0;
            r_wb_data <= 32'd0;
            r_wb_we   <= 1'b0;
            r_wb_sel  <= 4'd0;
            r_wb_stb  <= 1'b0;
            r_wb_cyc  <= 1'b0;
            r_rd_buf  <= 32'd0;
        end else begin
            if (w_start) begin
                r_wb_addr <= cpu_addr_i;
                r_wb_data <= cpu_data_i;
                r_wb_we   <= cpu_we_i;
                r_wb_sel  <= cpu_sel_i;
                r_wb_stb  <= 1'b1;
                r_wb_cyc  <= 1'b1;
            end else if (w_done || w_drop || w_tmo) begin
                r_wb_we   <= 1'b0;
                r_wb_sel  <= 4'd0;
                r_wb_stb  <= 1'b0;
                r_wb_cyc  <= 1'b0;
            end
            if (w_done) begin
                r_rd_buf <= r_wb_we ? 32'd0 : wb_data_i;
            end
        end
    end

    // Output logic: stall request and read data toward the pipeline
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = 32'd0;
        case (r_state)
            S_IDLE: begin
                stallreq_o = cpu_ce_i && !flush_i;
                cpu_data_o = 32'd0;
            end
            S_BUSY: begin
                if (flush_i) begin
                    stallreq_o = 1'b0;
                    cpu_data_o = 32'd0;
                end else if (wb_ack_i) begin
                    stallreq_o = 1'b0;
                    cpu_data_o = r_wb_we ? 32'd0 : wb_data_i;
                end else if (w_tmo) begin
                    stallreq_o = 1'b0;
                    cpu_data_o = 32'd0;
                end else begin
                    stallreq_o = 1'b1;
                    cpu_data_o = 32'd0;
                end
            end
            S_WAIT: begin
                stallreq_o = 1'b0;
                cpu_data_o = r_rd_buf;
            end
            default: begin
                stallreq_o = 1'b0;
                cpu_data_o = 32'd0;
            end
        endcase
    end

    assign wb_addr_o = r_wb_addr;
    assign wb_data_o = r_wb_data;
    assign wb_we_o   = r_wb_we;
    assign wb_sel_o  = r_wb_sel;
    assign wb_stb_o  = r_wb_stb;
    assign wb_cyc_o  = r_wb_cyc;

endmodule

// File: tb/tb_wb_bus_master_if.sv
// Directed self-checking bench for wb_bus_master_if (IF-port instance, STALL_BIT=1).
module tb_wb_bus_master_if;

`ifdef WB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk;
    logic        rst_n;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        bus_err_o;

    int n_pass  = 0;
    int n_total = 0;

    wb_bus_master_if #(.STALL_BIT(1), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .wb_data_i  (wb_data_i),
        .wb_ack_i   (wb_ack_i),
        .wb_addr_o  (wb_addr_o),
        .wb_data_o  (wb_data_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .bus_err_o  (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_i = 6'd0; flush_i = 1'b0; cpu_ce_i = 1'b0;
        cpu_addr_i = 32'd0; cpu_data_i = 32'd0; cpu_we_i = 1'b0; cpu_sel_i = 4'd0;
        wb_data_i = 32'd0; wb_ack_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_total++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) $display("FAIL rst_ctl: got %b expected 000", {wb_cyc_o, wb_stb_o, wb_we_o}); else n_pass++;
        n_total++; if (wb_sel_o !== 4'h0) $display("FAIL rst_sel: got %h expected 0", wb_sel_o); else n_pass++;
        n_total++; if (wb_addr_o !== 32'h0) $display("FAIL rst_addr: got %h expected 0", wb_addr_o); else n_pass++;
        n_total++; if (wb_data_o !== 32'h0) $display("FAIL rst_wdata: got %h expected 0", wb_data_o); else n_pass++;
        n_total++; if (stallreq_o !== 1'b0) $display("FAIL rst_stallreq: got %b expected 0", stallreq_o); else n_pass++;
        n_total++; if (cpu_data_o !== 32'h0) $display("FAIL rst_cpu_data: got %h expected 0", cpu_data_o); else n_pass++;
        n_total++; if (bus_err_o !== 1'b0) $display("FAIL rst_bus_err: got %b expected 0", bus_err_o); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h100; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
        wb_data_i = 32'hDEADBEEF; wb_ack_i = 1'b0;
        @(negedge clk);
        n_total++; if (stallreq_o !== 1'b1) $display("FAIL rd_req_stallreq: got %b expected 1", stallreq_o); else n_pass++;
        n_total++; if (wb_cyc_o !== 1'b0) $display("FAIL rd_req_cyc: got %b expected 0", wb_cyc_o); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b110) $display("FAIL rd_busy_ctl: got %b expected 110", {wb_cyc_o, wb_stb_o, wb_we_o}); else n_pass++;
        n_total++; if (wb_addr_o !== 32'h100) $display("FAIL rd_busy_addr: got %h expected 100", wb_addr_o); else n_pass++;
        n_total++; if (wb_sel_o !== 4'hF) $display("FAIL rd_busy_sel: got %h expected f", wb_sel_o); else n_pass++;
        n_total++; if (stallreq_o !== 1'b1) $display("FAIL rd_busy_stallreq: got %b expected 1", stallreq_o); else n_pass++;
        n_total++; if (cpu_data_o !== 32'h0) $display("FAIL rd_busy_data: got %h expected 0", cpu_data_o); else n_pass++;
        tick();
        wb_ack_i = 1'b1;
        @(negedge clk);
        n_total++; if (wb_cyc_o !== 1'b1) $display("FAIL rd_ack_cyc: got %b expected 1", wb_cyc_o); else n_pass++;
        n_total++; if (stallreq_o !== 1'b0) $display("FAIL rd_ack_stallreq: got %b expected 0", stallreq_o); else n_pass++;
        n_total++; if (cpu_data_o !== 32'hDEADBEEF) $display("FAIL rd_ack_data: got %h expected deadbeef", cpu_data_o); else n_pass++;
        tick();
        cpu_ce_i = 1'b0; wb_ack_i = 1'b0;
        @(negedge clk);
        n_total++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) $display("FAIL rd_done_cyc: got %b expected 00", {wb_cyc_o, wb_stb_o}); else n_pass++;
        n_total++; if (cpu_data_o !== 32'h0) $display("FAIL rd_done_data: got %h expected 0", cpu_data_o); else n_pass++;
        tick();
    endtask

    task automatic test_write();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h200; cpu_data_i = 32'h12345678;
        cpu_sel_i = 4'h3; wb_data_i = 32'hFFFFFFFF; wb_ack_i = 1'b0;
        @(negedge clk);
        n_total++; if (stallreq_o !== 1'b1) $display("FAIL wr_req_stallreq: got %b expected 1", stallreq_o); else n_pass++;
        tick();
        wb_ack_i = 1'b1;
        @(negedge clk);
        n_total++; if (wb_addr_o !== 32'h200) $display("FAIL wr_addr: got %h expected 200", wb_addr_o); else n_pass++;
        n_total++; if (wb_data_o !== 32'h12345678) $display("FAIL wr_wdata: got %h expected 12345678", wb_data_o); else n_pass++;
        n_total++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111) $display("FAIL wr_ctl: got %b expected 111", {wb_cyc_o, wb_stb_o, wb_we_o}); else n_pass++;
        n_total++; if (wb_sel_o !== 4'h3) $display("FAIL wr_sel: got %h expected 3", wb_sel_o); else n_pass++;
        n_total++; if (stallreq_o !== 1'b0) $display("FAIL wr_ack_stallreq: got %b expected 0", stallreq_o); else n_pass++;
        n_total++; if (cpu_data_o !== 32'h0) $display("FAIL wr_ack_data: got %h expected 0", cpu_data_o); else n_pass++;
        tick();
        cpu_ce_i = 1'b0; cpu_we_i = 1'b0; wb_ack_i = 1'b0;
        @(negedge clk);
        n_total++; if ({wb_cyc_o, wb_we_o, wb_sel_o} !== 6'b000000) $display("FAIL wr_done_ctl: got %b expected 000000", {wb_cyc_o, wb_we_o, wb_sel_o}); else n_pass++;
        tick();
    endtask

    task automatic test_foreign_stall();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h300; cpu_sel_i = 4'hF;
        tick();
        wb_ack_i = 1'b1; wb_data_i = 32'hA5A5A5A5; stall_i = 6'b011111;
        @(negedge clk);
        n_total++; if (cpu_data_o !== 32'hA5A5A5A5) $display("FAIL fs_ack_data: got %h expected a5a5a5a5", cpu_data_o); else n_pass++;
        tick();
        wb_ack_i = 1'b0; wb_data_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++; if (cpu_data_o !== 32'hA5A5A5A5) $display("FAIL fs_hold_data[%0d]: got %h expected a5a5a5a5", i, cpu_data_o); else n_pass++;
            n_total++; if (stallreq_o !== 1'b0) $display("FAIL fs_hold_stallreq[%0d]: got %b expected 0", i, stallreq_o); else n_pass++;
            n_total++; if (wb_cyc_o !== 1'b0) $display("FAIL fs_hold_cyc[%0d]: got %b expected 0", i, wb_cyc_o); else n_pass++;
            tick();
        end
        stall_i = 6'd0; cpu_ce_i = 1'b0;
        @(negedge clk);
        n_total++; if (cpu_data_o !== 32'hA5A5A5A5) $display("FAIL fs_release_data: got %h expected a5a5a5a5", cpu_data_o); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (cpu_data_o !== 32'h0) $display("FAIL fs_idle_data: got %h expected 0", cpu_data_o); else n_pass++;
        n_total++; if (wb_cyc_o !== 1'b0) $display("FAIL fs_idle_cyc: got %b expected 0", wb_cyc_o); else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h400; cpu_sel_i = 4'hF;
        tick();
        @(negedge clk);
        n_total++; if (stallreq_o !== 1'b1) $display("FAIL fl_busy_stallreq: got %b expected 1", stallreq_o); else n_pass++;
        tick();
        wb_ack_i = 1'b1; flush_i = 1'b1; wb_data_i = 32'h11111111;
        @(negedge clk);
        n_total++; if (stallreq_o !== 1'b0) $display("FAIL fl_ack_stallreq: got %b expected 0", stallreq_o); else n_pass++;
        n_total++; if (cpu_data_o !== 32'h0) $display("FAIL fl_ack_data: got %h expected 0", cpu_data_o); else n_pass++;
        tick();
        wb_ack_i = 1'b0;
        @(negedge clk);
        n_total++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) $display("FAIL fl_after_cyc: got %b expected 00", {wb_cyc_o, wb_stb_o}); else n_pass++;
        n_total++; if (stallreq_o !== 1'b0) $display("FAIL fl_idle_stallreq: got %b expected 0", stallreq_o); else n_pass++;
        n_total++; if (cpu_data_o !== 32'h0) $display("FAIL fl_idle_data: got %h expected 0", cpu_data_o); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (wb_cyc_o !== 1'b0) $display("FAIL fl_no_start: got %b expected 0", wb_cyc_o); else n_pass++;
        flush_i = 1'b0; cpu_ce_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h600; cpu_sel_i = 4'hF;
        tick();
        wb_ack_i = 1'b1; wb_data_i = 32'hCAFEF00D; stall_i = 6'b111101;
        @(negedge clk);
        n_total++; if (cpu_data_o !== 32'hCAFEF00D) $display("FAIL b2b_first_data: got %h expected cafef00d", cpu_data_o); else n_pass++;
        tick();
        wb_ack_i = 1'b0; cpu_addr_i = 32'h604; stall_i = 6'd0;
        @(negedge clk);
        n_total++; if (wb_cyc_o !== 1'b0) $display("FAIL b2b_gap_cyc: got %b expected 0", wb_cyc_o); else n_pass++;
        n_total++; if (stallreq_o !== 1'b1) $display("FAIL b2b_gap_stallreq: got %b expected 1", stallreq_o); else n_pass++;
        tick();
        wb_ack_i = 1'b1; wb_data_i = 32'h0BADF00D;
        @(negedge clk);
        n_total++; if (wb_cyc_o !== 1'b1) $display("FAIL b2b_second_cyc: got %b expected 1", wb_cyc_o); else n_pass++;
        n_total++; if (wb_addr_o !== 32'h604) $display("FAIL b2b_second_addr: got %h expected 604", wb_addr_o); else n_pass++;
        n_total++; if (cpu_data_o !== 32'h0BADF00D) $display("FAIL b2b_second_data: got %h expected 0badf00d", cpu_data_o); else n_pass++;
        tick();
        cpu_ce_i = 1'b0; wb_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h500; cpu_sel_i = 4'hF;
        tick();
        @(negedge clk);
        n_total++; if (wb_cyc_o !== 1'b1) $display("FAIL rm_busy_cyc: got %b expected 1", wb_cyc_o); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) $display("FAIL rm_async_cyc: got %b expected 00", {wb_cyc_o, wb_stb_o}); else n_pass++;
        cpu_ce_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_total++; if (stallreq_o !== 1'b0) $display("FAIL rm_after_stallreq: got %b expected 0", stallreq_o); else n_pass++;
        n_total++; if (wb_cyc_o !== 1'b0) $display("FAIL rm_after_cyc: got %b expected 0", wb_cyc_o); else n_pass++;
        tick();
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h700; cpu_sel_i = 4'hF; wb_ack_i = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++; if (stallreq_o !== 1'b1) $display("FAIL to_wait_stallreq[%0d]: got %b expected 1", i, stallreq_o); else n_pass++;
            n_total++; if (bus_err_o !== 1'b0) $display("FAIL to_wait_err[%0d]: got %b expected 0", i, bus_err_o); else n_pass++;
            tick();
        end
        @(negedge clk);
        n_total++; if (stallreq_o !== 1'b0) $display("FAIL to_abort_stallreq: got %b expected 0", stallreq_o); else n_pass++;
        n_total++; if (cpu_data_o !== 32'h0) $display("FAIL to_abort_data: got %h expected 0", cpu_data_o); else n_pass++;
        tick();
        cpu_ce_i = 1'b0;
        @(negedge clk);
        n_total++; if (bus_err_o !== 1'b1) $display("FAIL to_err_pulse: got %b expected 1", bus_err_o); else n_pass++;
        n_total++; if (wb_cyc_o !== 1'b0) $display("FAIL to_err_cyc: got %b expected 0", wb_cyc_o); else n_pass++;
        tick();
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h704;
        @(negedge clk);
        n_total++; if (bus_err_o !== 1'b0) $display("FAIL to_err_end: got %b expected 0", bus_err_o); else n_pass++;
        tick();
        wb_ack_i = 1'b1; wb_data_i = 32'h77777777;
        @(negedge clk);
        n_total++; if (wb_addr_o !== 32'h704) $display("FAIL to_next_addr: got %h expected 704", wb_addr_o); else n_pass++;
        n_total++; if (cpu_data_o !== 32'h77777777) $display("FAIL to_next_data: got %h expected 77777777", cpu_data_o); else n_pass++;
        tick();
        cpu_ce_i = 1'b0; wb_ack_i = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_foreign_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid_access();
`ifdef WB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
